// File: rtl/vram_arbiter.sv
// Three-way arbiter in front of the single-port 32-bit VRAM: CPU register port plus two
// layer renderers, each using a strobe/ack handshake with read data returned in the ack cycle.
//
// state | meaning
// IDLE  | arbitrate among eligible requesters, launch address and write strobe
// ADDR  | RAM samples address; write strobe dropped at the end of this cycle
// DATA  | RAM returns data; granted port's rddata and ack registered at the edge
module vram_arbiter #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wrdata,
  input  logic [3:0]        cpu_bytesel,
  input  logic              cpu_write,
  input  logic              cpu_strobe,
  output logic [31:0]       cpu_rddata,
  output logic              cpu_ack,
  input  logic [ADDR_W-1:0] l0_addr,
  input  logic              l0_strobe,
  output logic [31:0]       l0_rddata,
  output logic              l0_ack,
  input  logic [ADDR_W-1:0] l1_addr,
  input  logic              l1_strobe,
  output logic [31:0]       l1_rddata,
  output logic              l1_ack,
  output logic [ADDR_W-3:0] ram_addr,
  output logic [31:0]       ram_wrdata,
  output logic [3:0]        ram_wrbytesel,
  output logic              ram_write,
  input  logic [31:0]       ram_rddata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [1:0] G_CPU = 2'd0;
  localparam logic [1:0] G_L0  = 2'd1;
  localparam logic [1:0] G_L1  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic              ptr_q, ptr_d;            // 0: layer 0 preferred, 1: layer 1 preferred
  logic              cpu_last_q, cpu_last_d;
  logic [ADDR_W-3:0] ram_addr_q, ram_addr_d;
  logic [31:0]       ram_wrdata_q, ram_wrdata_d;
  logic [3:0]        ram_wrbytesel_q, ram_wrbytesel_d;
  logic              ram_write_q, ram_write_d;
  logic [31:0]       cpu_rddata_q, cpu_rddata_d;
  logic [31:0]       l0_rddata_q, l0_rddata_d;
  logic [31:0]       l1_rddata_q, l1_rddata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              l0_ack_q, l0_ack_d;
  logic              l1_ack_q, l1_ack_d;

  logic elig_cpu, elig_l0, elig_l1;
  logic sel_cpu, sel_l0, sel_l1;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{cpu_addr[1:0], l0_addr[1:0], l1_addr[1:0]};

  // A port whose ack is high this cycle may still show a stale strobe; keep it out.
  assign elig_cpu = cpu_strobe & ~cpu_ack_q;
  assign elig_l0  = l0_strobe & ~l0_ack_q;
  assign elig_l1  = l1_strobe & ~l1_ack_q;

  assign sel_cpu = elig_cpu & ~(cpu_last_q & (elig_l0 | elig_l1));
  assign sel_l0  = ~sel_cpu & elig_l0 & ~(elig_l1 & ptr_q);
  assign sel_l1  = ~sel_cpu & elig_l1 & ~(elig_l0 & ~ptr_q);

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    ptr_d           = ptr_q;
    cpu_last_d      = cpu_last_q;
    ram_addr_d      = ram_addr_q;
    ram_wrdata_d    = ram_wrdata_q;
    ram_wrbytesel_d = ram_wrbytesel_q;
    ram_write_d     = ram_write_q;
    cpu_rddata_d    = cpu_rddata_q;
    l0_rddata_d     = l0_rddata_q;
    l1_rddata_d     = l1_rddata_q;
    cpu_ack_d       = 1'b0;
    l0_ack_d        = 1'b0;
    l1_ack_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (sel_cpu) begin
          state_d     = S_ADDR;
          grant_d     = G_CPU;
          cpu_last_d  = 1'b1;
          ram_addr_d  = cpu_addr[ADDR_W-1:2];
          ram_write_d = cpu_write;
          if (cpu_write) begin
            ram_wrbytesel_d = cpu_bytesel;
            ram_wrdata_d    = cpu_wrdata;
          end else begin
            ram_wrbytesel_d = 4'b0000;
          end
        end else if (sel_l0) begin
          state_d         = S_ADDR;
          grant_d         = G_L0;
          cpu_last_d      = 1'b0;
          ptr_d           = 1'b1;
          ram_addr_d      = l0_addr[ADDR_W-1:2];
          ram_write_d     = 1'b0;
          ram_wrbytesel_d = 4'b0000;
        end else if (sel_l1) begin
          state_d         = S_ADDR;
          grant_d         = G_L1;
          cpu_last_d      = 1'b0;
          ptr_d           = 1'b0;
          ram_addr_d      = l1_addr[ADDR_W-1:2];
          ram_write_d     = 1'b0;
          ram_wrbytesel_d = 4'b0000;
        end
      end
      S_ADDR: begin
        state_d         = S_DATA;
        ram_write_d     = 1'b0;
        ram_wrbytesel_d = 4'b0000;
      end
      S_DATA: begin
        state_d = S_IDLE;
        case (grant_q)
          G_CPU: begin
            cpu_rddata_d = ram_rddata;
            cpu_ack_d    = 1'b1;
          end
          G_L0: begin
            l0_rddata_d = ram_rddata;
            l0_ack_d    = 1'b1;
          end
          G_L1: begin
            l1_rddata_d = ram_rddata;
            l1_ack_d    = 1'b1;
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      grant_q         <= G_CPU;
      ptr_q           <= 1'b0;
      cpu_last_q      <= 1'b0;
      ram_addr_q      <= '0;
      ram_wrdata_q    <= '0;
      ram_wrbytesel_q <= '0;
      ram_write_q     <= 1'b0;
      cpu_rddata_q    <= '0;
      l0_rddata_q     <= '0;
      l1_rddata_q     <= '0;
      cpu_ack_q       <= 1'b0;
      l0_ack_q        <= 1'b0;
      l1_ack_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      ptr_q           <= ptr_d;
      cpu_last_q      <= cpu_last_d;
      ram_addr_q      <= ram_addr_d;
      ram_wrdata_q    <= ram_wrdata_d;
      ram_wrbytesel_q <= ram_wrbytesel_d;
      ram_write_q     <= ram_write_d;
      cpu_rddata_q    <= cpu_rddata_d;
      l0_rddata_q     <= l0_rddata_d;
      l1_rddata_q     <= l1_rddata_d;
      cpu_ack_q       <= cpu_ack_d;
      l0_ack_q        <= l0_ack_d;
      l1_ack_q        <= l1_ack_d;
    end
  end

  assign ram_addr      = ram_addr_q;
  assign ram_wrdata    = ram_wrdata_q;
  assign ram_wrbytesel = ram_wrbytesel_q;
  assign ram_write     = ram_write_q;
  assign cpu_rddata    = cpu_rddata_q;
  assign cpu_ack       = cpu_ack_q;
  assign l0_rddata     = l0_rddata_q;
  assign l0_ack        = l0_ack_q;
  assign l1_rddata     = l1_rddata_q;
  assign l1_ack        = l1_ack_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: directed requests push expected acks into a queue,
// a negedge monitor pops and compares every ack the DUT presents.
module tb_vram_arbiter;

  typedef struct {
    int          port;   // 0 cpu, 1 layer 0, 2 layer 1
    logic [31:0] data;
    bit          dc;     // read data don't-care (write acks)
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] cpu_addr = '0;
  logic [31:0] cpu_wrdata = '0;
  logic [3:0]  cpu_bytesel = '0;
  logic        cpu_write = 1'b0;
  logic        cpu_strobe = 1'b0;
  logic [31:0] cpu_rddata;
  logic        cpu_ack;
  logic [17:0] l0_addr = '0;
  logic        l0_strobe = 1'b0;
  logic [31:0] l0_rddata;
  logic        l0_ack;
  logic [17:0] l1_addr = '0;
  logic        l1_strobe = 1'b0;
  logic [31:0] l1_rddata;
  logic        l1_ack;
  logic [15:0] ram_addr;
  logic [31:0] ram_wrdata;
  logic [3:0]  ram_wrbytesel;
  logic        ram_write;
  logic [31:0] ram_rddata = '0;

  logic [31:0] mem [256];
  logic        mem_init = 1'b1;

  exp_t exp_q[$];
  int   nvec = 0;
  int   nerr = 0;

  vram_arbiter #(.ADDR_W(18)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata), .cpu_bytesel(cpu_bytesel),
    .cpu_write(cpu_write), .cpu_strobe(cpu_strobe), .cpu_rddata(cpu_rddata), .cpu_ack(cpu_ack),
    .l0_addr(l0_addr), .l0_strobe(l0_strobe), .l0_rddata(l0_rddata), .l0_ack(l0_ack),
    .l1_addr(l1_addr), .l1_strobe(l1_strobe), .l1_rddata(l1_rddata), .l1_ack(l1_ack),
    .ram_addr(ram_addr), .ram_wrdata(ram_wrdata), .ram_wrbytesel(ram_wrbytesel),
    .ram_write(ram_write), .ram_rddata(ram_rddata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'hDEADBEEF;
      8:       return 32'h0808A0A0;
      9:       return 32'h0909B1B1;
      'h41:    return 32'hAAAAAAAA;
      'h50:    return 32'h55555555;
      default: return 32'h0;
    endcase
  endfunction

  // RAM model: address sampled at the edge, data valid the following cycle.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else begin
      ram_rddata <= mem[ram_addr[7:0]];
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_wrbytesel[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wrdata[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic ack_of(input int port);
    case (port)
      0:       return cpu_ack;
      1:       return l0_ack;
      default: return l1_ack;
    endcase
  endfunction

  // Monitor: every ack must match the head of the expected queue.
  int          mon_n;
  int          mon_port;
  logic [31:0] mon_data;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      mon_n = int'(cpu_ack) + int'(l0_ack) + int'(l1_ack);
      if (mon_n > 1) chk("ack_onehot", mon_n, 1);
      else if (mon_n == 1) begin
        mon_port = l0_ack ? 1 : (l1_ack ? 2 : 0);
        mon_data = l0_ack ? l0_rddata : (l1_ack ? l1_rddata : cpu_rddata);
        if (exp_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL unexpected_ack: port %0d acked with nothing expected", mon_port);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_port", mon_port, mon_e.port);
          if (!mon_e.dc) chk("ack_data", mon_data, mon_e.data);
        end
      end
    end
  end

  task automatic push_exp(input int port, input logic [31:0] data, input bit dc);
    exp_t e;
    e.port = port;
    e.data = data;
    e.dc   = dc;
    exp_q.push_back(e);
  endtask

  task automatic wait_ack(input int port, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ack_of(port) && cyc < 20);
    if (!ack_of(port)) chk("ack_timeout", 0, 1);
  endtask

  task automatic drop_all();
    cpu_strobe = 1'b0;
    cpu_write  = 1'b0;
    l0_strobe  = 1'b0;
    l1_strobe  = 1'b0;
  endtask

  // Holds current strobes until n acks appear, checking the 3-cycle spacing.
  task automatic run_stream(input int n, input string tag);
    int got = 0;
    int cyc = 0;
    int last = 0;
    while (got < n && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack | l0_ack | l1_ack) begin
        got++;
        chk({tag, "_spacing"}, cyc - last, 3);
        last = cyc;
      end
    end
    drop_all();
    chk({tag, "_count"}, got, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outs", {ram_write, cpu_ack, l0_ack, l1_ack, ram_wrbytesel}, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wrdata", ram_wrdata, 0);
    chk("rst_rddata", cpu_rddata | l0_rddata | l1_rddata, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  int lat, wcnt, tc, tl, cyc;

  initial begin
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    do_reset();

    // 1: isolated layer 0 read
    l0_addr = 18'h00010;
    l0_strobe = 1'b1;
    push_exp(1, 32'hDEADBEEF, 0);
    @(posedge clk);
    #1;
    chk("t1_ram_addr", ram_addr, 16'd4);
    wait_ack(1, lat);
    chk("t1_latency", lat + 0, 3);
    l0_strobe = 1'b0;
    repeat (2) @(negedge clk);

    // 2: CPU write, one-cycle write pulse
    cpu_addr = 18'h00104;
    cpu_wrdata = 32'h11223344;
    cpu_bytesel = 4'b0101;
    cpu_write = 1'b1;
    cpu_strobe = 1'b1;
    push_exp(0, 32'h0, 1);
    wcnt = 0;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      if (ram_write) begin
        wcnt++;
        chk("t2_ram_addr", ram_addr, 16'h41);
        chk("t2_bytesel", ram_wrbytesel, 4'b0101);
        chk("t2_wrdata", ram_wrdata, 32'h11223344);
      end
      @(negedge clk);
      cyc++;
    end while (!cpu_ack && cyc < 20);
    chk("t2_write_width", wcnt, 1);
    chk("t2_latency", cyc, 3);
    drop_all();
    @(negedge clk);
    chk("t2_mem_merge", mem[8'h41], 32'hAA22AA44);

    // 3: both layers stream after reset, l0 first
    do_reset();
    l0_addr = 18'h00020;
    l1_addr = 18'h00024;
    for (int i = 0; i < 6; i++) push_exp((i % 2) + 1, (i % 2) ? 32'h0909B1B1 : 32'h0808A0A0, 0);
    l0_strobe = 1'b1;
    l1_strobe = 1'b1;
    run_stream(6, "t3");
    repeat (2) @(negedge clk);

    // 4: CPU plus both layers: CPU,l0,CPU,l1,CPU,l0
    cpu_addr = 18'h00104;
    cpu_write = 1'b0;
    push_exp(0, 32'hAA22AA44, 0);
    push_exp(1, 32'h0808A0A0, 0);
    push_exp(0, 32'hAA22AA44, 0);
    push_exp(2, 32'h0909B1B1, 0);
    push_exp(0, 32'hAA22AA44, 0);
    push_exp(1, 32'h0808A0A0, 0);
    cpu_strobe = 1'b1;
    l0_strobe = 1'b1;
    l1_strobe = 1'b1;
    run_stream(6, "t4");
    repeat (2) @(negedge clk);

    // 5: CPU and l0 together, CPU first, l0 three cycles later
    push_exp(0, 32'hAA22AA44, 0);
    push_exp(1, 32'h0808A0A0, 0);
    cpu_strobe = 1'b1;
    l0_strobe = 1'b1;
    tc = 0;
    tl = 0;
    cyc = 0;
    while ((tc == 0 || tl == 0) && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack) begin tc = cyc; cpu_strobe = 1'b0; end
      if (l0_ack) begin tl = cyc; l0_strobe = 1'b0; end
    end
    chk("t5_cpu_latency", tc, 3);
    chk("t5_l0_after_cpu", tl - tc, 3);
    drop_all();
    repeat (2) @(negedge clk);

    // 6: reset during ADDR of a CPU write
    cpu_addr = 18'h00140;
    cpu_wrdata = 32'h12345678;
    cpu_bytesel = 4'b1111;
    cpu_write = 1'b1;
    cpu_strobe = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_write_launched", ram_write, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_write_killed", {ram_write, ram_wrbytesel}, 0);
    chk("t6_acks_zero", {cpu_ack, l0_ack, l1_ack}, 0);
    drop_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_no_write", mem[8'h50], 32'h55555555);
    l1_addr = 18'h00024;
    l1_strobe = 1'b1;
    push_exp(2, 32'h0909B1B1, 0);
    wait_ack(2, lat);
    chk("t6_l1_latency", lat, 3);
    l1_strobe = 1'b0;
    chk("t6_rddata_hold", cpu_rddata | l0_rddata, 0);

    repeat (4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
